fifo_drain_ctrl: RTL and testbench

//  Read-side controller for the shift-register queue. Issues Deque strobes, captures the queue's registered

---
 rtl/fifo_drain_ctrl_if.sv | 31 +++
 rtl/fifo_drain_ctrl.sv | 125 ++++++++++++
 tb/tb_fifo_drain_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_drain_ctrl_if.sv
// Bundles the queue-side and stream-side signals of the drain controller.
// The controller uses master; the queue, producer and stream consumer use slave.
interface fifo_drain_ctrl_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8
);
  logic                   Start;
  logic [COUNT_WIDTH-1:0] BurstLen;
  logic                   Abort;
  logic [DATA_WIDTH-1:0]  FifoData;
  logic                   FifoEmpty;
  logic                   FifoEnque;
  logic                   Deque;
  logic [DATA_WIDTH-1:0]  OutData;
  logic                   OutValid;
  logic                   OutReady;
  logic                   Busy;
  logic                   Done;
  logic                   Timeout;
  logic [COUNT_WIDTH-1:0] WordsOut;

  modport master (
    input  Start, BurstLen, Abort, FifoData, FifoEmpty, FifoEnque, OutReady,
    output Deque, OutData, OutValid, Busy, Done, Timeout, WordsOut
  );

  modport slave (
    output Start, BurstLen, Abort, FifoData, FifoEmpty, FifoEnque, OutReady,
    input  Deque, OutData, OutValid, Busy, Done, Timeout, WordsOut
  );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller for the shift-register queue.
// It dequeues a burst, or drains until empty, and delivers the words through a 2-entry skid buffer.
module fifo_drain_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8,
  parameter int TIMEOUT     = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  fifo_drain_ctrl_if.master bus
);
  localparam int STALL_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

  state_t                 state;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   unbounded;
  logic                   pending;
  logic [DATA_WIDTH-1:0]  skid [2];
  logic [1:0]             skid_count;
  logic [STALL_W-1:0]     stall_count;
  logic                   busy;
  logic                   done;
  logic                   timeout;
  logic [COUNT_WIDTH-1:0] words_out;
  logic                   deque;
  logic                   xfer;
  logic [1:0]             base_count;
  logic                   stall_tick;

  // A word in flight reserves a skid slot, so dequeue only while a slot is guaranteed.
  always_comb begin
    deque = (state == DRAIN) && !bus.Abort && ((remaining != '0) || unbounded) &&
            !bus.FifoEmpty && !bus.FifoEnque &&
            (({1'b0, skid_count} + {2'b00, pending}) < 3'd2);
    xfer       = (skid_count != 2'd0) && bus.OutReady;
    base_count = skid_count - {1'b0, xfer};
    stall_tick = !unbounded && bus.FifoEmpty && !bus.FifoEnque;
  end

  assign bus.Deque    = deque;
  assign bus.OutData  = skid[0];
  assign bus.OutValid = (skid_count != 2'd0);
  assign bus.Busy     = busy;
  assign bus.Done     = done;
  assign bus.Timeout  = timeout;
  assign bus.WordsOut = words_out;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state       <= IDLE;
      remaining   <= '0;
      unbounded   <= 1'b0;
      pending     <= 1'b0;
      skid[0]     <= '0;
      skid[1]     <= '0;
      skid_count  <= 2'd0;
      stall_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      words_out   <= '0;
    end else begin
      pending <= deque;
      if (deque && !unbounded)
        remaining <= remaining - COUNT_WIDTH'(1);

      // Pop shifts the tail forward; a capture in the same cycle lands behind what remains.
      if (xfer) begin
        skid[0]   <= skid[1];
        words_out <= words_out + COUNT_WIDTH'(1);
      end
      if (pending)
        skid[base_count[0]] <= bus.FifoData;
      skid_count <= base_count + {1'b0, pending};

      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start) begin
            state       <= DRAIN;
            busy        <= 1'b1;
            remaining   <= bus.BurstLen;
            unbounded   <= (bus.BurstLen == '0);
            words_out   <= '0;
            timeout     <= 1'b0;
            stall_count <= '0;
          end
        end
        DRAIN: begin
          if (deque)
            stall_count <= '0;
          else if (stall_tick)
            stall_count <= stall_count + STALL_W'(1);

          if (bus.Abort)
            state <= FLUSH;
          else if (!unbounded && (remaining == '0))
            state <= FLUSH;
          else if (unbounded && bus.FifoEmpty)
            state <= FLUSH;
          else if (stall_tick && (stall_count == STALL_W'(TIMEOUT - 1))) begin
            timeout <= 1'b1;
            state   <= FLUSH;
          end
        end
        FLUSH: begin
          if (!pending && (skid_count == 2'd0)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl with a behavioural queue and a stream monitor.
module tb_fifo_drain_ctrl;
  logic Clk = 1'b0;
  logic Reset_n;
  int   errors = 0;
  int   checks = 0;

  fifo_drain_ctrl_if #(.DATA_WIDTH(8), .COUNT_WIDTH(8)) bus ();

  fifo_drain_ctrl #(.DATA_WIDTH(8), .COUNT_WIDTH(8), .TIMEOUT(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
  );

  always #5 Clk = ~Clk;

  // Queue model: enqueue has priority, DataOut is registered after an accepted dequeue.
  logic [7:0] qMem [0:15];
  logic [4:0] qCount;
  logic [7:0] qOut;
  logic [7:0] enqData;
  logic       qClear;

  assign bus.FifoData  = qOut;
  assign bus.FifoEmpty = (qCount == 5'd0);

  always @(posedge Clk) begin
    if (qClear)
      qCount <= 5'd0;
    else if (bus.FifoEnque) begin
      qMem[qCount[3:0]] <= enqData;
      qCount <= qCount + 5'd1;
    end else if (bus.Deque && (qCount != 5'd0)) begin
      qOut <= qMem[0];
      for (int i = 0; i < 15; i++) qMem[i] <= qMem[i+1];
      qCount <= qCount - 5'd1;
    end
  end

  logic [7:0] gotMem [0:255];
  logic [7:0] gotN = 8'd0;
  logic [7:0] dqN  = 8'd0;

  always @(posedge Clk) begin
    if (bus.OutValid && bus.OutReady) begin
      gotMem[gotN] = bus.OutData;
      gotN = gotN + 8'd1;
    end
    if (bus.Deque) dqN = dqN + 8'd1;
  end

  task pushWords(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                 input logic [7:0] w3, input logic [7:0] w4, input int n);
    logic [7:0] w [5];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3; w[4] = w4;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      bus.FifoEnque = 1'b1;
      enqData = w[i];
    end
    @(negedge Clk);
    bus.FifoEnque = 1'b0;
  endtask

  task clearQueue;
    @(negedge Clk) qClear = 1'b1;
    @(negedge Clk) qClear = 1'b0;
  endtask

  task startBurst(input logic [7:0] len);
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.BurstLen = len;
    @(negedge Clk);
    bus.Start = 1'b0;
  endtask

  task waitDone(input int maxc, input string name);
    int n;
    n = 0;
    while (bus.Done !== 1'b1 && n < maxc) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (bus.Done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_done: Done=%b after %0d cycles, required 1", name, bus.Done, n);
    end
  endtask

  task checkWords(input logic [7:0] g0, input int n, input logic [7:0] e0, input logic [7:0] e1,
                  input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4, input string name);
    logic [7:0] e [5];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
    checks++;
    if ((gotN - g0) !== 8'(n)) begin
      errors++;
      $display("[TB] FAIL %s_count: got %0d words, required %0d", name, gotN - g0, n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (gotMem[g0 + 8'(i)] !== e[i]) begin
        errors++;
        $display("[TB] FAIL %s_word%0d: got %h, required %h", name, i, gotMem[g0 + 8'(i)], e[i]);
      end
    end
  endtask

  task test_reset;
    Reset_n = 1'b0;
    bus.Start = 1'b1;
    bus.BurstLen = 8'd3;
    bus.Abort = 1'b0;
    bus.FifoEnque = 1'b0;
    bus.OutReady = 1'b1;
    enqData = 8'h00;
    qClear = 1'b1;
    @(negedge Clk);
    qClear = 1'b0;
    pushWords(8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checks++;
      if ({bus.Deque, bus.OutValid, bus.Busy, bus.Done, bus.Timeout, bus.OutData, bus.WordsOut} !== 21'd0) begin
        errors++;
        $display("[TB] FAIL reset_outputs: D=%b V=%b B=%b Dn=%b T=%b data=%h words=%0d, required all 0",
                 bus.Deque, bus.OutValid, bus.Busy, bus.Done, bus.Timeout, bus.OutData, bus.WordsOut);
      end
    end
    bus.Start = 1'b0;
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if ({bus.Done, bus.Busy, bus.Deque} !== 3'b000 || qCount !== 5'd3) begin
      errors++;
      $display("[TB] FAIL reset_release: Done=%b Busy=%b Deque=%b qCount=%0d, required 0 0 0 3",
               bus.Done, bus.Busy, bus.Deque, qCount);
    end
    clearQueue();
  endtask

  task test_bounded;
    logic [7:0] g0, d0;
    bus.OutReady = 1'b1;
    pushWords(8'h44, 8'h33, 8'h22, 8'h11, 8'h00, 4);
    g0 = gotN; d0 = dqN;
    startBurst(8'd3);
    waitDone(40, "bounded");
    checks++;
    if (bus.WordsOut !== 8'd3 || bus.Timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bounded_status: WordsOut=%0d Timeout=%b, required 3 0", bus.WordsOut, bus.Timeout);
    end
    @(negedge Clk);
    checks++;
    if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bounded_pulse: Done=%b Busy=%b one cycle later, required 0 0", bus.Done, bus.Busy);
    end
    checkWords(g0, 3, 8'h44, 8'h33, 8'h22, 8'h00, 8'h00, "bounded");
    checks++;
    if ((dqN - d0) !== 8'd3 || qCount !== 5'd1 || qMem[0] !== 8'h11) begin
      errors++;
      $display("[TB] FAIL bounded_queue: deques=%0d left=%0d head=%h, required 3 1 11", dqN - d0, qCount, qMem[0]);
    end
    clearQueue();
  endtask

  task test_backpressure;
    logic [7:0] g0, d0;
    bus.OutReady = 1'b0;
    pushWords(8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'h00, 4);
    g0 = gotN; d0 = dqN;
    startBurst(8'd4);
    repeat (8) @(negedge Clk);
    checks++;
    if ((dqN - d0) !== 8'd2 || bus.OutValid !== 1'b1 || bus.OutData !== 8'hB1) begin
      errors++;
      $display("[TB] FAIL bp_stall: deques=%0d OutValid=%b OutData=%h, required 2 1 b1", dqN - d0, bus.OutValid, bus.OutData);
    end
    repeat (3) @(negedge Clk);
    checks++;
    if ((dqN - d0) !== 8'd2 || bus.OutData !== 8'hB1) begin
      errors++;
      $display("[TB] FAIL bp_hold: deques=%0d OutData=%h, required 2 b1", dqN - d0, bus.OutData);
    end
    bus.OutReady = 1'b1;
    waitDone(40, "bp");
    checks++;
    if (bus.WordsOut !== 8'd4 || (dqN - d0) !== 8'd4) begin
      errors++;
      $display("[TB] FAIL bp_status: WordsOut=%0d deques=%0d, required 4 4", bus.WordsOut, dqN - d0);
    end
    checkWords(g0, 4, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'h00, "bp");
    @(negedge Clk);
  endtask

  task test_unbounded;
    logic [7:0] g0;
    bus.OutReady = 1'b1;
    pushWords(8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 5);
    g0 = gotN;
    startBurst(8'd0);
    waitDone(60, "unbounded");
    checks++;
    if (bus.WordsOut !== 8'd5 || bus.Timeout !== 1'b0 || qCount !== 5'd0) begin
      errors++;
      $display("[TB] FAIL unbounded_status: WordsOut=%0d Timeout=%b left=%0d, required 5 0 0", bus.WordsOut, bus.Timeout, qCount);
    end
    checkWords(g0, 5, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, "unbounded");
    @(negedge Clk);
  endtask

  task test_timeout;
    logic [7:0] g0;
    int emptyN, n;
    bus.OutReady = 1'b1;
    pushWords(8'hD1, 8'hD2, 8'h00, 8'h00, 8'h00, 2);
    g0 = gotN;
    startBurst(8'd6);
    emptyN = 0; n = 0;
    while (bus.Timeout !== 1'b1 && n < 60) begin
      if (bus.FifoEmpty && bus.Busy) emptyN++;
      @(negedge Clk);
      n++;
    end
    checks++;
    if (bus.Timeout !== 1'b1 || emptyN != 16) begin
      errors++;
      $display("[TB] FAIL timeout_cycles: Timeout=%b after %0d empty cycles, required 1 after 16", bus.Timeout, emptyN);
    end
    waitDone(20, "timeout");
    checks++;
    if (bus.WordsOut !== 8'd2) begin
      errors++;
      $display("[TB] FAIL timeout_words: WordsOut=%0d, required 2", bus.WordsOut);
    end
    checkWords(g0, 2, 8'hD1, 8'hD2, 8'h00, 8'h00, 8'h00, "timeout");
    repeat (2) @(negedge Clk);
    checks++;
    if (bus.Timeout !== 1'b1 || bus.Busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_sticky: Timeout=%b Busy=%b in idle, required 1 0", bus.Timeout, bus.Busy);
    end
  endtask

  task test_collisions;
    logic [7:0] g0, d0, d1;
    int n;
    bus.OutReady = 1'b1;
    pushWords(8'hE1, 8'hE2, 8'hE3, 8'h00, 8'h00, 3);
    g0 = gotN; d0 = dqN;
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.BurstLen = 8'd3;
    @(negedge Clk);
    bus.Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.FifoEnque = 1'b1;
      enqData = 8'hF0 + 8'(i);
      #1;
      checks++;
      if (bus.Deque !== 1'b0 || bus.Busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL enque_block%0d: Deque=%b Busy=%b, required 0 1", i, bus.Deque, bus.Busy);
      end
      @(negedge Clk);
    end
    bus.FifoEnque = 1'b0;
    d1 = dqN;
    checks++;
    if (d1 !== d0) begin
      errors++;
      $display("[TB] FAIL enque_nodeque: deques=%0d during enque, required 0", d1 - d0);
    end
    waitDone(40, "enque");
    checkWords(g0, 3, 8'hE1, 8'hE2, 8'hE3, 8'h00, 8'h00, "enque");

    g0 = gotN; d0 = dqN;
    startBurst(8'd3);
    n = 0;
    while (bus.Deque !== 1'b1 && n < 10) begin
      @(negedge Clk);
      n++;
    end
    @(negedge Clk);
    bus.Abort = 1'b1;
    #1;
    checks++;
    if (bus.Deque !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_deque: Deque=%b with Abort, required 0", bus.Deque);
    end
    waitDone(20, "abort");
    bus.Abort = 1'b0;
    checks++;
    if (bus.WordsOut !== 8'd1 || (dqN - d0) !== 8'd1) begin
      errors++;
      $display("[TB] FAIL abort_status: WordsOut=%0d deques=%0d, required 1 1", bus.WordsOut, dqN - d0);
    end
    checkWords(g0, 1, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, "abort");

    @(negedge Clk);
    bus.OutReady = 1'b0;
    startBurst(8'd2);
    repeat (3) @(negedge Clk);
    checks++;
    if (bus.Busy !== 1'b1 || bus.OutValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_pre: Busy=%b OutValid=%b, required 1 1", bus.Busy, bus.OutValid);
    end
    Reset_n = 1'b0;
    @(negedge Clk);
    checks++;
    if ({bus.OutValid, bus.Busy, bus.Deque, bus.WordsOut} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL rst_mid: OutValid=%b Busy=%b Deque=%b WordsOut=%0d, required all 0",
               bus.OutValid, bus.Busy, bus.Deque, bus.WordsOut);
    end
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    checks++;
    if ({bus.Busy, bus.Done, bus.OutValid} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL rst_idle: Busy=%b Done=%b OutValid=%b, required 0 0 0", bus.Busy, bus.Done, bus.OutValid);
    end
  endtask

  initial begin
    test_reset();
    test_bounded();
    test_backpressure();
    test_unbounded();
    test_timeout();
    test_collisions();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
